echo_detector: RTL and testbench
================================

// Module: echo_detector
// PURPOSE
//  Sonar echo detector fed by FIR_Filter output (Y -> x, same en strobe).
//  Rectifies each filtered sample, forms an envelope, and after a programmable
//  blanking window timestamps the first sample whose envelope crosses threshold
//  (time-of-flight in samples). Result is held for the CPU with a one-cycle irq.
// PARAMETERS
//  N    16  sample width; x is two's-complement
//  CW   16  sample-counter / tof width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  en         in   1   sample strobe, one cycle per valid x
//  x          in   N   filtered sample
//  start      in   1   pulse: arm a new measurement
//  blank_len  in   CW  samples ignored after start (transmit ring-down)
//  max_len    in   CW  listen-window length in samples (timeout)
//  thresh     in   N   envelope detection threshold, unsigned
//  busy       out  1   high in BLANK or LISTEN
//  done       out  1   high in DONE; held until next accepted start
//  detected   out  1   valid when done: 1 = echo found, 0 = timeout
//  tof        out  CW  sample index of detection (from start); all-ones on timeout
//  peak       out  N   max envelope seen in LISTEN, up to and incl. detect sample
//  irq        out  1   one-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset: state=IDLE; busy,done,detected,irq=0; tof=0; peak=0; cnt=0; env=0.
//  Rectify: a = |x|; x = -2^(N-1) saturates to 2^(N-1)-1; a is N bits unsigned.
//  States IDLE -> BLANK -> LISTEN -> DONE; inputs are sampled only on en cycles.
//  - IDLE/DONE: start=1 -> BLANK; cnt,tof,peak,env,detected,done cleared.
//    start in BLANK/LISTEN ignored. start and en same cycle: en sample dropped.
//  - BLANK: each en: cnt<=cnt+1; when cnt+1 == blank_len -> LISTEN.
//    blank_len=0: leave BLANK next cycle without needing en.
//  - LISTEN: each en: update env (see CONFIGURATION) using a; peak<=max(peak,env').
//    env' >= thresh -> tof<=cnt, detected<=1, -> DONE.
//    else cnt<=cnt+1; listen count reaches max_len -> tof<=all-ones,
//    detected<=0, -> DONE. max_len=0: timeout on first LISTEN en, no compare.
//  - Compare uses the newly computed env' (same-cycle), not the old register.
//  - Detection and timeout on same en: detection wins.
//  - cnt saturates at all-ones; never wraps.
//  Latency: done/irq/tof/peak visible the cycle after the deciding en.
//  irq asserted exactly one cycle per measurement; never during rst.
//  rst mid-measurement: abort to IDLE, all outputs to reset values, no irq.
//  blank_len,max_len,thresh sampled live; software holds them stable while busy.
// CONFIGURATION
//  ECHO_ENV_SMOOTH_EN defined: env' = env + ((a - env) >>> 2), signed N+1-bit
//   difference, arithmetic shift; env cleared on start (one-pole IIR, alpha=1/4).
//  Not defined: env' = a (raw rectified sample); no env state retained.
// TESTING (raw env unless noted)
//  rst; blank_len=4,max_len=100,thresh=1000; start; 10 en with x=0, then x=1200
//   -> detected=1, tof=10, peak=1200, irq 1 cycle, done held until next start.
//  blank_len=8; x=5000 on en #2..#5, then 0 -> no detect in BLANK; after 100 LISTEN
//   en -> done=1, detected=0, tof=16'hFFFF, irq once.
//  x=-32768 first LISTEN sample, thresh=32767 -> a=32767, detected=1, peak=32767.
//  SMOOTH_EN: thresh=750, blank_len=0, x=1000 each en -> env 250,437,577,682,761;
//   detect at tof=4, peak=761.
//  rst asserted while LISTEN after 5 en -> busy=0, done=0, no irq; new start works.
//  start pulsed while busy -> ignored, tof unchanged; start with en same cycle ->
//   that sample not counted.

Source files
------------

// File: rtl/echo_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : echo_detector_if
//  Description : Sample/control/result bundle for echo_detector. The master
//                side drives the filtered sample stream and the measurement
//                set-up; the slave side (the detector) returns status and
//                the time-of-flight result.
//  Revision    : 1.0  initial release
// ============================================================================
interface echo_detector_if #(
    parameter int N  = 16,
    parameter int CW = 16
);
    logic          en;
    logic [N-1:0]  x;
    logic          start;
    logic [CW-1:0] blank_len;
    logic [CW-1:0] max_len;
    logic [N-1:0]  thresh;
    logic          busy;
    logic          done;
    logic          detected;
    logic [CW-1:0] tof;
    logic [N-1:0]  peak;
    logic          irq;

    modport master (
        output en, x, start, blank_len, max_len, thresh,
        input  busy, done, detected, tof, peak, irq
    );

    modport slave (
        input  en, x, start, blank_len, max_len, thresh,
        output busy, done, detected, tof, peak, irq
    );
endinterface
`default_nettype wire

// File: rtl/echo_detector.sv
`default_nettype none
// ============================================================================
//  Module      : echo_detector
//  Description : Sonar echo detector. Rectifies each filtered sample, forms an
//                envelope and, after a blanking window, timestamps the first
//                sample whose envelope reaches the threshold. The result is
//                held until the next start and announced with a 1-cycle irq.
//                Optional macro ECHO_ENV_SMOOTH_EN selects a one-pole IIR
//                envelope (alpha = 1/4); otherwise the envelope is the raw
//                rectified sample.
//  Revision    : 1.0  initial release
// ============================================================================
module echo_detector #(
    parameter int N  = 16,
    parameter int CW = 16
) (
    input  wire            clk,
    input  wire            rst,
    echo_detector_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_LISTEN = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [N-1:0]  c_x_min   = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  c_a_max   = {1'b0, {(N-1){1'b1}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;        // samples since start (blank + listen)
    logic [CW-1:0] r_lcnt;       // samples consumed in LISTEN
    logic [CW-1:0] r_tof;
    logic [N-1:0]  r_peak;
    logic          r_detected;
    logic          r_irq;

    logic [N-1:0]  w_a;
    logic [N-1:0]  w_env_nxt;
    logic [CW:0]   w_cnt_p1;
    logic [CW:0]   w_lcnt_p1;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_lcnt_inc;
    logic          w_start_ok;
    logic          w_blank_step;
    logic          w_blank_exit;
    logic          w_listen_en;
    logic          w_hit;
    logic          w_timeout;

    // Rectify the two's-complement sample; the most negative code saturates.
    always_comb begin
        w_a = bus.x;
        if (bus.x == c_x_min) begin
            w_a = c_a_max;
        end else if (bus.x[N-1]) begin
            w_a = -bus.x;
        end
    end

`ifdef ECHO_ENV_SMOOTH_EN
    logic [N-1:0]    r_env;
    logic signed [N:0] w_diff;
    logic [N-1:0]    w_step;

    // One-pole IIR: env' = env + ((a - env) >>> 2), signed difference.
    always_comb begin
        w_diff    = $signed({1'b0, w_a}) - $signed({1'b0, r_env});
        w_step    = N'(w_diff >>> 2);
        w_env_nxt = r_env + w_step;
    end

    // Envelope state: cleared on an accepted start, updated per LISTEN sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_env <= '0;
        end else if (w_start_ok) begin
            r_env <= '0;
        end else if (w_listen_en) begin
            r_env <= w_env_nxt;
        end
    end
`else
    assign w_env_nxt = w_a;
`endif

    // Counter increments (saturating) and per-cycle decisions.
    always_comb begin
        w_cnt_p1     = {1'b0, r_cnt} + (CW+1)'(1);
        w_lcnt_p1    = {1'b0, r_lcnt} + (CW+1)'(1);
        w_cnt_inc    = w_cnt_p1[CW]  ? r_cnt  : w_cnt_p1[CW-1:0];
        w_lcnt_inc   = w_lcnt_p1[CW] ? r_lcnt : w_lcnt_p1[CW-1:0];
        w_start_ok   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
        // A zero-length blank window exits immediately and consumes no sample.
        w_blank_step = (r_state == S_BLANK) && bus.en && (bus.blank_len != '0);
        w_blank_exit = (r_state == S_BLANK) &&
                       ((bus.blank_len == '0) ||
                        (bus.en && (w_cnt_p1 == {1'b0, bus.blank_len})));
        w_listen_en  = (r_state == S_LISTEN) && bus.en;
        // Detection beats timeout; a zero-length window never compares.
        w_hit        = w_listen_en && (bus.max_len != '0) &&
                       (w_env_nxt >= bus.thresh);
        w_timeout    = w_listen_en && !w_hit &&
                       ((bus.max_len == '0) || (w_lcnt_p1 >= {1'b0, bus.max_len}));
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_BLANK;
            S_BLANK:        if (w_blank_exit) w_state_nxt = S_LISTEN;
            S_LISTEN:       if (w_hit || w_timeout) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Measurement datapath: counters, result capture and the irq pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_lcnt     <= '0;
            r_tof      <= '0;
            r_peak     <= '0;
            r_detected <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= w_hit || w_timeout;
            if (w_start_ok) begin
                r_cnt      <= '0;
                r_lcnt     <= '0;
                r_tof      <= '0;
                r_peak     <= '0;
                r_detected <= 1'b0;
            end
            if (w_blank_step) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_listen_en) begin
                if (w_env_nxt > r_peak) begin
                    r_peak <= w_env_nxt;
                end
                if (w_hit) begin
                    r_tof      <= r_cnt;
                    r_detected <= 1'b1;
                end else begin
                    r_cnt  <= w_cnt_inc;
                    r_lcnt <= w_lcnt_inc;
                    if (w_timeout) begin
                        r_tof      <= c_cnt_max;
                        r_detected <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.busy     = (r_state == S_BLANK) || (r_state == S_LISTEN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.detected = r_detected;
    assign bus.tof      = r_tof;
    assign bus.peak     = r_peak;
    assign bus.irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_echo_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_detector
//  Description : Self-checking bench for echo_detector. Stimulus pushes the
//                expected result of each measurement into a queue; a monitor
//                pops and compares on every irq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_echo_detector;
    localparam int N  = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    echo_detector_if #(.N(N), .CW(CW)) bus();
    echo_detector #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        det;
        logic [15:0] tof;
        logic [15:0] peak;
    } exp_t;

    exp_t q[$];
    int   script[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_irq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // |x| with the most negative code clipped to the largest positive value.
    function automatic int rect(input logic [15:0] xv);
        int xi;
        xi = int'($signed(xv));
        if (xi < 0) xi = -xi;
        if (xi > 32767) xi = 32767;
        return xi;
    endfunction

    function automatic logic [15:0] genx(input int mode, input int th, input int s);
        int r;
        int amp;
        if (mode == 2) return (s < script.size()) ? 16'(script[s]) : 16'd0;
        r = $urandom_range(0, 11);
        if (r == 0) return 16'h8000;
        if (r <= 2) return 16'($urandom);
        amp = $urandom_range(0, th / 2);
        return ($urandom_range(0, 1) == 1) ? 16'(-amp) : 16'(amp);
    endfunction

    // Monitor: every irq must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.irq) chk("irq_in_rst", {31'd0, bus.irq}, 32'd0);
        end else if (bus.irq) begin
            chk("irq_width", {31'd0, prev_irq}, 32'd0);
            if (q.size() == 0) begin
                chk("irq_unexpected", 32'd1, 32'd0);
            end else begin
                chk("detected", {31'd0, bus.detected}, {31'd0, q[0].det});
                chk("tof",      {16'd0, bus.tof},      {16'd0, q[0].tof});
                chk("peak",     {16'd0, bus.peak},     {16'd0, q[0].peak});
                chk("done_at_irq", {31'd0, bus.done}, 32'd1);
                chk("busy_at_irq", {31'd0, bus.busy}, 32'd0);
                void'(q.pop_front());
            end
        end
        prev_irq <= bus.irq;
    end

    // One measurement: start, then sample stream until the reference model
    // decides. Model: the first bl accepted samples are blanked; listen sample
    // k yields an envelope; detect if env >= th, else time out after ml samples.
    task automatic measure(input int bl, input int ml, input int th, input int mode,
                           input bit start_en);
        int          s       = 0;
        int          cyc     = 0;
        int          env     = 0;
        int          peak    = 0;
        int          a;
        int          n;
        bit          decided = 0;
        bit          e;
        logic [15:0] xv;
        exp_t        ex;
        bus.blank_len = bl[15:0];
        bus.max_len   = ml[15:0];
        bus.thresh    = th[15:0];
        bus.start     = 1'b1;
        bus.en        = start_en;
        bus.x         = 16'($urandom);
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        chk("done_after_start", {31'd0, bus.done}, 32'd0);
        while (!decided && cyc < 5000) begin
            e = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (cyc == 0 && bl == 0) e = 1'b0;
            xv        = genx(mode, th, s);
            bus.en    = e;
            bus.x     = xv;
            bus.start = (mode != 2) && ($urandom_range(0, 15) == 0);
            if (e) begin
                if (s >= bl) begin
                    a = rect(xv);
`ifdef ECHO_ENV_SMOOTH_EN
                    env = env + ((a - env) >>> 2);
`else
                    env = a;
`endif
                    if (env > peak) peak = env;
                    ex.peak = 16'(peak);
                    if (ml == 0 || (env < th && (s - bl + 1) >= ml)) begin
                        ex.det = 1'b0; ex.tof = 16'hFFFF; q.push_back(ex); decided = 1;
                    end else if (env >= th) begin
                        ex.det = 1'b1; ex.tof = (s > 65535) ? 16'hFFFF : 16'(s);
                        q.push_back(ex); decided = 1;
                    end
                end
                s++;
            end
            tick();
            cyc++;
        end
        bus.en    = 1'b0;
        bus.start = 1'b0;
        if (!decided) chk("model_decided", 32'd0, 32'd1);
        n = 0;
        while (!bus.done && n < 4) begin
            tick();
            n++;
        end
        chk("done_rise", {31'd0, bus.done}, 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        chk("done_hold", {31'd0, bus.done}, 32'd1);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.start = 1'b0; bus.x = '0;
        bus.blank_len = '0; bus.max_len = '0; bus.thresh = '0;
        repeat (3) tick();
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_done",     {31'd0, bus.done},     32'd0);
        chk("rst_detected", {31'd0, bus.detected}, 32'd0);
        chk("rst_irq",      {31'd0, bus.irq},      32'd0);
        chk("rst_tof",      {16'd0, bus.tof},      32'd0);
        chk("rst_peak",     {16'd0, bus.peak},     32'd0);
        rst = 1'b0;
        tick();

`ifndef ECHO_ENV_SMOOTH_EN
        // Echo at sample 10; the sample issued with start is dropped.
        script.delete();
        for (int i = 0; i < 10; i++) script.push_back(0);
        script.push_back(1200);
        measure(4, 100, 1000, 2, 1'b1);
        chk("s1_det",  {31'd0, bus.detected}, 32'd1);
        chk("s1_tof",  {16'd0, bus.tof},      32'd10);
        chk("s1_peak", {16'd0, bus.peak},     32'd1200);

        // Strong burst inside the blank window, then silence -> timeout.
        script.delete();
        script.push_back(0);
        for (int i = 0; i < 4; i++) script.push_back(5000);
        measure(8, 100, 1000, 2, 1'b0);
        chk("s2_det",  {31'd0, bus.detected}, 32'd0);
        chk("s2_tof",  {16'd0, bus.tof},      32'h0000FFFF);
        chk("s2_peak", {16'd0, bus.peak},     32'd0);

        // Most negative code on the first listen sample.
        script.delete();
        script.push_back(0);
        script.push_back(0);
        script.push_back(32768);
        measure(2, 10, 32767, 2, 1'b0);
        chk("s3_det",  {31'd0, bus.detected}, 32'd1);
        chk("s3_tof",  {16'd0, bus.tof},      32'd2);
        chk("s3_peak", {16'd0, bus.peak},     32'd32767);
`else
        // Smoothed envelope 250,437,577,682,761 crosses 750 on sample 4.
        script.delete();
        for (int i = 0; i < 10; i++) script.push_back(1000);
        measure(0, 100, 750, 2, 1'b0);
        chk("sm_det",  {31'd0, bus.detected}, 32'd1);
        chk("sm_tof",  {16'd0, bus.tof},      32'd4);
        chk("sm_peak", {16'd0, bus.peak},     32'd761);
`endif

        // Zero-length listen window: immediate timeout even with thresh 0.
        script.delete();
        measure(3, 0, 0, 2, 1'b0);
        chk("ml0_det", {31'd0, bus.detected}, 32'd0);
        chk("ml0_tof", {16'd0, bus.tof},      32'h0000FFFF);

        // Reset in the middle of LISTEN aborts without an irq.
        bus.blank_len = 16'd2; bus.max_len = 16'd100; bus.thresh = 16'hFFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.en = 1'b1; bus.x = 16'd1000;
        repeat (7) tick();
        bus.en = 1'b0;
        rst = 1'b1;
        tick();
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_tof",  {16'd0, bus.tof},  32'd0);
        chk("abort_peak", {16'd0, bus.peak}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomised measurements.
        for (int i = 0; i < 40; i++) begin
            measure($urandom_range(0, 20), $urandom_range(1, 60),
                    $urandom_range(100, 30000), 0, 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
